// File: rtl/enet_rgmii_rxframe.sv
// RGMII receive framer: reassembles DDR pin samples into bytes, strips preamble/SFD
// and emits a framed byte stream. Define ENET_RX_INBAND_STATUS_EN for in-band status decode.
module enet_rgmii_rxframe #(
  parameter int LGMAXLEN = 14,
  parameter int MAX_LEN  = 1522
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [7:0]          i_rxd,
  input  logic [1:0]          i_rxctl,
  output logic                o_valid,
  output logic [7:0]          o_data,
  output logic                o_last,
  output logic                o_err,
  output logic [LGMAXLEN-1:0] o_len,
  output logic                o_link_up,
  output logic [1:0]          o_speed,
  output logic                o_full_duplex
);

  // Handshake: o_valid is a one-cycle strobe with no ready; o_last/o_err/o_len
  // are meaningful only while o_valid is high. The wire cannot be stalled.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  localparam logic [7:0]          PRE_BYTE = 8'h55;
  localparam logic [7:0]          SFD_BYTE = 8'hD5;
  localparam logic [LGMAXLEN-1:0] CNT_MAX  = LGMAXLEN'(MAX_LEN);
  localparam logic [LGMAXLEN-1:0] CNT_ONE  = LGMAXLEN'(1);

  state_t r_state;
  state_t w_next;

  logic [7:0] r_byte;
  logic       r_dv;
  logic       r_er;

  logic [7:0]          r_hold;
  logic                r_held;
  logic [LGMAXLEN-1:0] r_cnt;
  logic                r_flag;

  logic                r_valid;
  logic [7:0]          r_data;
  logic                r_last;
  logic                r_err;
  logic [LGMAXLEN-1:0] r_len;

  logic [7:0]          w_hold;
  logic                w_held;
  logic [LGMAXLEN-1:0] w_cnt;
  logic                w_flag;
  logic                w_valid;
  logic [7:0]          w_data;
  logic                w_last;
  logic                w_err;
  logic [LGMAXLEN-1:0] w_len;

  // Stage 1 is deliberately not reset so the byte seen at reset release is still judged.
  always_ff @(posedge i_clk) begin
    r_byte <= {i_rxd[6], i_rxd[4], i_rxd[2], i_rxd[0],
               i_rxd[7], i_rxd[5], i_rxd[3], i_rxd[1]};
    r_dv   <= i_rxctl[1];
    r_er   <= i_rxctl[1] ^ i_rxctl[0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= i_rxctl[1] ? S_DROP : S_IDLE;
      r_hold  <= 8'h00;
      r_held  <= 1'b0;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_len   <= '0;
    end else begin
      r_state <= w_next;
      r_hold  <= w_hold;
      r_held  <= w_held;
      r_cnt   <= w_cnt;
      r_flag  <= w_flag;
      r_valid <= w_valid;
      r_data  <= w_data;
      r_last  <= w_last;
      r_err   <= w_err;
      r_len   <= w_len;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_hold  = r_hold;
    w_held  = r_held;
    w_cnt   = r_cnt;
    w_flag  = r_flag;
    w_valid = 1'b0;
    w_data  = r_data;
    w_last  = 1'b0;
    w_err   = 1'b0;
    w_len   = r_len;
    case (r_state)
      S_IDLE: begin
        // dv=0 with er=1 is false carrier / carrier extension and is ignored
        if (r_dv) begin
          if (r_byte == PRE_BYTE) begin
            w_next = S_PREAMBLE;
          end else if (r_byte == SFD_BYTE) begin
            w_next = S_DATA;
            w_held = 1'b0;
            w_cnt  = '0;
            w_flag = 1'b0;
          end else begin
            w_next = S_DROP;
          end
        end
      end
      S_PREAMBLE: begin
        if (!r_dv) begin
          w_next = S_IDLE;
        end else if (r_byte == SFD_BYTE) begin
          w_next = S_DATA;
          w_held = 1'b0;
          w_cnt  = '0;
          w_flag = 1'b0;
        end else if (r_byte != PRE_BYTE) begin
          w_next = S_DROP;
        end
      end
      S_DATA: begin
        if (r_dv) begin
          if (r_cnt == CNT_MAX) begin
            // Byte MAX_LEN+1: close the frame on the held byte as an error
            w_valid = 1'b1;
            w_data  = r_hold;
            w_last  = 1'b1;
            w_err   = 1'b1;
            w_len   = r_cnt;
            w_held  = 1'b0;
            w_next  = S_DROP;
          end else begin
            w_valid = r_held;
            if (r_held) begin
              w_data = r_hold;
            end
            w_hold = r_byte;
            w_held = 1'b1;
            w_cnt  = r_cnt + CNT_ONE;
            w_flag = r_flag | r_er;
          end
        end else begin
          if (r_held) begin
            w_valid = 1'b1;
            w_data  = r_hold;
            w_last  = 1'b1;
            w_err   = r_flag;
            w_len   = r_cnt;
          end
          w_held = 1'b0;
          w_next = S_IDLE;
        end
      end
      S_DROP: begin
        if (!r_dv) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_err   = r_err;
  assign o_len   = r_len;

`ifdef ENET_RX_INBAND_STATUS_EN
  logic       r_link_up;
  logic [1:0] r_speed;
  logic       r_full_duplex;

  // Status is only carried on clean inter-frame cycles; frames leave it untouched.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_link_up     <= 1'b0;
      r_speed       <= 2'b00;
      r_full_duplex <= 1'b0;
    end else if (!r_dv && !r_er) begin
      r_link_up     <= r_byte[0];
      r_speed       <= r_byte[2:1];
      r_full_duplex <= r_byte[3];
    end
  end

  assign o_link_up     = r_link_up;
  assign o_speed       = r_speed;
  assign o_full_duplex = r_full_duplex;
`else
  assign o_link_up     = 1'b0;
  assign o_speed       = 2'b00;
  assign o_full_duplex = 1'b0;
`endif

endmodule

// File: tb/tb_enet_rgmii_rxframe.sv
// Bench for enet_rgmii_rxframe: frames driven byte by byte, expected output bytes
// queued with their arrival cycle and matched by a monitor.
module tb_enet_rgmii_rxframe;

  localparam int LG      = 14;
  localparam int MAX_LEN = 64;
  localparam int W       = 24;

`ifdef ENET_RX_INBAND_STATUS_EN
  localparam logic [3:0] EXP_ST = 4'b1101;
`else
  localparam logic [3:0] EXP_ST = 4'b0000;
`endif

  logic          clk;
  logic          i_reset_n;
  logic [7:0]    i_rxd;
  logic [1:0]    i_rxctl;
  logic          o_valid;
  logic [7:0]    o_data;
  logic          o_last;
  logic          o_err;
  logic [LG-1:0] o_len;
  logic          o_link_up;
  logic [1:0]    o_speed;
  logic          o_full_duplex;

  enet_rgmii_rxframe #(.LGMAXLEN(LG), .MAX_LEN(MAX_LEN)) dut (
    .i_clk        (clk),
    .i_reset_n    (i_reset_n),
    .i_rxd        (i_rxd),
    .i_rxctl      (i_rxctl),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_last       (o_last),
    .o_err        (o_err),
    .o_len        (o_len),
    .o_link_up    (o_link_up),
    .o_speed      (o_speed),
    .o_full_duplex(o_full_duplex)
  );

  // clock / reset
  initial clk = 1'b0;
  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, queued=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];   // {last, err, len[13:0], data[7:0]}
  int           exp_t_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [7:0]   idle_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  logic [W-1:0] mon_e;
  int           mon_t;
  always @(negedge clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {24'd0, o_data}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        check("data", {24'd0, o_data}, {24'd0, mon_e[7:0]});
        check("last", {31'd0, o_last}, {31'd0, mon_e[23]});
        check("latency", cyc, mon_t);
        if (mon_e[23]) begin
          check("err", {31'd0, o_err}, {31'd0, mon_e[22]});
          check("len", {18'd0, o_len}, {18'd0, mon_e[21:8]});
        end
      end
    end else if (exp_t_q.size() > 0 && exp_t_q[0] <= cyc) begin
      mon_e = exp_q.pop_front();
      mon_t = exp_t_q.pop_front();
      check("missing_byte", 32'd0, {24'd0, mon_e[7:0]});
    end
  end

  // driver tasks
  task automatic drive(input logic [7:0] b, input logic dv, input logic er, input logic rst_n);
    @(negedge clk);
    i_reset_n = rst_n;
    i_rxctl   = {dv, dv ^ er};
    for (int k = 0; k < 4; k++) begin
      i_rxd[2*k+1] = b[k];
      i_rxd[2*k]   = b[k+4];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(idle_byte, 1'b0, 1'b0, 1'b1);
  endtask

  // rst_at > 0 pulses reset during that payload byte with dv still high
  task automatic send_frame(input int npre, input bit bad, input int n, input int er_idx,
                            input int rst_at, input bit rnd, input int gap);
    logic [7:0]    d;
    int            nout;
    logic          ferr;
    logic          lst;
    bit            keep;
    logic [LG-1:0] len;
    nout = (n > MAX_LEN) ? MAX_LEN : n;
    ferr = (n > MAX_LEN) || (er_idx >= 1 && er_idx <= nout);
    len  = LG'(nout);
    for (int i = 0; i < npre; i++) drive(8'h55, 1'b1, 1'b0, 1'b1);
    if (bad) drive(8'h5A, 1'b1, 1'b0, 1'b1);
    drive(8'hD5, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= n; i++) begin
      d = rnd ? 8'($urandom_range(0, 255)) : 8'(i - 1);
      drive(d, 1'b1, (i == er_idx), !(rst_at > 0 && i == rst_at));
      keep = !bad && ((rst_at == 0) ? (i <= nout) : (i <= rst_at - 3));
      lst  = (rst_at == 0) && (i == nout);
      if (keep) begin
        exp_q.push_back({lst, lst ? ferr : 1'b0, lst ? len : LG'(0), d});
        exp_t_q.push_back(cyc + 3);
      end
      if (rst_at > 0 && i == rst_at + 1) begin
        check("rst_valid_clear", {31'd0, o_valid}, 32'd0);
        check("rst_last_clear", {31'd0, o_last}, 32'd0);
      end
    end
    idle(gap);
  endtask

  function automatic logic [31:0] status();
    return {28'd0, o_full_duplex, o_speed, o_link_up};
  endfunction

  initial begin
    i_reset_n = 1'b0;
    i_rxd     = 8'h00;
    i_rxctl   = 2'b00;
    for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_last", {31'd0, o_last}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_data", {24'd0, o_data}, 32'd0);
    check("rst_len", {18'd0, o_len}, 32'd0);
    check("rst_status", status(), 32'd0);
    idle(5);

    // long preamble, incrementing 64-byte payload (exactly MAX_LEN)
    send_frame(7, 1'b0, 64, 0, 0, 1'b0, 12);
    // corrupted preamble dropped, next frame intact
    send_frame(1, 1'b1, 20, 0, 0, 1'b1, 12);
    send_frame(7, 1'b0, 10, 0, 0, 1'b1, 12);
    // rx error mid-frame
    send_frame(7, 1'b0, 30, 10, 0, 1'b1, 12);
    // overflow, then a normal frame
    send_frame(7, 1'b0, 70, 0, 0, 1'b1, 12);
    send_frame(7, 1'b0, 16, 0, 0, 1'b1, 12);
    // short preamble, one-byte frame, empty frame, error on final byte
    send_frame(0, 1'b0, 5, 0, 0, 1'b1, 6);
    send_frame(7, 1'b0, 1, 0, 0, 1'b1, 6);
    send_frame(7, 1'b0, 0, 0, 0, 1'b1, 6);
    send_frame(3, 1'b0, 64, 64, 0, 1'b1, 6);
    // false carrier between frames
    for (int i = 0; i < 3; i++) drive(8'h0E, 1'b0, 1'b1, 1'b1);
    send_frame(7, 1'b0, 12, 0, 0, 1'b1, 8);
    // reset pulse at payload byte 20, then a clean frame
    send_frame(7, 1'b0, 40, 0, 20, 1'b1, 12);
    send_frame(7, 1'b0, 25, 0, 0, 1'b1, 12);
    // random frames, lengths spanning the overflow boundary
    for (int f = 0; f < 5; f++) begin
      send_frame($urandom_range(0, 7), 1'b0, $urandom_range(1, 80),
                 $urandom_range(0, 90), 0, 1'b1, $urandom_range(2, 10));
    end

    // in-band status
    idle_byte = 8'h0D;
    idle(4);
    check("status_idle", status(), {28'd0, EXP_ST});
    for (int i = 0; i < 2; i++) drive(8'h02, 1'b0, 1'b1, 1'b1);
    check("status_false_carrier", status(), {28'd0, EXP_ST});
    send_frame(7, 1'b0, 20, 0, 0, 1'b0, 0);
    check("status_in_frame", status(), {28'd0, EXP_ST});
    idle(12);
    check("status_after_frame", status(), {28'd0, EXP_ST});

    idle(8);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
